// File: rtl/ioctl_upload_server.sv
// HPS ioctl upload responder: turns ioctl_rd strobes into reads on a variable-latency memory port.
// Define UPLOAD_CHECKSUM_EN to build the running modulo-256 checksum on upload_sum.
module ioctl_upload_server #(
    parameter int         ADDR_WIDTH   = 14,
    parameter int         REGION_SIZE  = 16384,
    parameter logic [7:0] UPLOAD_INDEX = 8'd0,
    parameter int         TIMEOUT      = 255,
    parameter logic [7:0] PAD_BYTE     = 8'hFF,
    parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ioctl_upload,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_rd,
    input  logic [24:0]           ioctl_addr,
    output logic [7:0]            ioctl_din,
    output logic                  ioctl_wait,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    output logic                  timeout_err,
    output logic [7:0]            upload_sum
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            din_q, din_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  timeout_err_q, timeout_err_d;
    logic                  upload_prev_q, upload_prev_d;

    logic                  accept;
    logic                  in_range;
    logic                  cnt_expired;
    logic                  session_start;
    logic                  deliver;
    logic                  timeout_set;
    logic [7:0]            deliver_byte;

    assign accept        = ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX) & (state_q == IDLE);
    assign in_range      = 32'(ioctl_addr) < 32'(REGION_SIZE);
    assign cnt_expired   = (cnt_q == 8'(TIMEOUT));
    assign session_start = ioctl_upload & ~upload_prev_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q       <= IDLE;
            din_q         <= 8'd0;
            addr_q        <= '0;
            cnt_q         <= 8'd0;
            timeout_err_q <= 1'b0;
            upload_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            din_q         <= din_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            upload_prev_q <= upload_prev_d;
        end
    end

    // Dropping the session aborts from any state; an ack on the same cycle is discarded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = in_range ? WAIT_ACK : DONE;
                end
            end
            WAIT_ACK: begin
                if (mem_ack || cnt_expired) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!ioctl_upload) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        deliver      = 1'b0;
        deliver_byte = din_q;
        timeout_set  = 1'b0;
        addr_d       = addr_q;
        cnt_d        = 8'd0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        addr_d = ioctl_addr[ADDR_WIDTH-1:0];
                        cnt_d  = 8'd1;
                    end else begin
                        deliver      = 1'b1;
                        deliver_byte = PAD_BYTE;
                    end
                end
            end
            WAIT_ACK: begin
                if (ioctl_upload) begin
                    if (mem_ack) begin
                        deliver      = 1'b1;
                        deliver_byte = mem_data;
                    end else if (cnt_expired) begin
                        deliver      = 1'b1;
                        deliver_byte = ERR_BYTE;
                        timeout_set  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
            end
        endcase
        din_d         = deliver ? deliver_byte : din_q;
        timeout_err_d = (session_start ? 1'b0 : timeout_err_q) | timeout_set;
        upload_prev_d = ioctl_upload;
    end

    always_comb begin
        ioctl_wait = accept | (state_q == WAIT_ACK);
        mem_rd     = (state_q == WAIT_ACK);
    end

    assign ioctl_din   = din_q;
    assign mem_addr    = addr_q;
    assign timeout_err = timeout_err_q;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_base;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    // A byte delivered on the session's first cycle still counts after the clear.
    always_comb begin
        sum_base = session_start ? 8'd0 : sum_q;
        sum_d    = deliver ? (sum_base + deliver_byte) : sum_base;
    end

    assign upload_sum = sum_q;
`else
    assign upload_sum = 8'd0;
`endif

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Self-checking bench for ioctl_upload_server: vector table plus corner-case sequences, scoreboard on ioctl_din.
module tb_ioctl_upload_server;

    localparam int TMO = 4;

    logic        clk_sys      = 1'b0;
    logic        reset        = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index  = 8'd0;
    logic        ioctl_rd     = 1'b0;
    logic [24:0] ioctl_addr   = 25'd0;
    logic        mem_ack      = 1'b0;
    logic [7:0]  mem_data     = 8'd0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic        timeout_err;
    logic [7:0]  upload_sum;

    always #5 clk_sys = ~clk_sys;

    ioctl_upload_server #(
        .ADDR_WIDTH  (14),
        .REGION_SIZE (16384),
        .UPLOAD_INDEX(8'd0),
        .TIMEOUT     (TMO),
        .PAD_BYTE    (8'hFF),
        .ERR_BYTE    (8'hEE)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .timeout_err (timeout_err),
        .upload_sum  (upload_sum)
    );

    typedef struct {
        logic [24:0] addr;
        int          ack_delay;
        logic [7:0]  data;
        logic [7:0]  exp_din;
        int          exp_waits;
        int          exp_memrd;
        logic        exp_terr;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] sb_q[$];
    logic [7:0] last_din = 8'd0;
    int         checks   = 0;
    int         errors   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected byte for a read: pad above the region, error byte if the ack never comes in time.
    function automatic logic [7:0] model_din(input logic [24:0] addr, input int ack_delay, input logic [7:0] data);
        if (addr >= 25'd16384) return 8'hFF;
        if (ack_delay < 1 || ack_delay > TMO) return 8'hEE;
        return data;
    endfunction

    task automatic do_read(input logic [24:0] addr, input int ack_delay, input logic [7:0] data,
                           output int waits, output int memrd_cnt);
        bit done;
        done      = 1'b0;
        waits     = 0;
        memrd_cnt = 0;
        @(negedge clk_sys);
        ioctl_rd    = 1'b1;
        ioctl_addr  = addr;
        ioctl_index = 8'd0;
        #1;
        if (ioctl_wait) waits++;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            mem_ack  = (k == ack_delay);
            mem_data = data;
            #1;
            if (mem_rd) begin
                memrd_cnt++;
                if (memrd_cnt == 1) check("mem_addr", 32'(mem_addr), 32'(addr[13:0]));
            end
            if (ioctl_wait) waits++;
            else done = 1'b1;
        end
        mem_ack = 1'b0;
        if (!done) check("wait_release", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic check_output(input string name);
        logic [7:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard empty, actual din=%0h", name, ioctl_din);
        end else begin
            exp = sb_q.pop_front();
            check(name, 32'(ioctl_din), 32'(exp));
            last_din = exp;
        end
    endtask

    task automatic apply_stimulus(input int idx);
        int waits, memrd_cnt;
        sb_q.push_back(vecs[idx].exp_din);
        do_read(vecs[idx].addr, vecs[idx].ack_delay, vecs[idx].data, waits, memrd_cnt);
        check($sformatf("v%0d_din", idx), 32'(ioctl_din), 32'(sb_q[0]));
        check_output($sformatf("v%0d_sb", idx));
        check($sformatf("v%0d_waits", idx), 32'(waits), 32'(vecs[idx].exp_waits));
        check($sformatf("v%0d_memrd", idx), 32'(memrd_cnt), 32'(vecs[idx].exp_memrd));
        check($sformatf("v%0d_terr", idx), 32'(timeout_err), 32'(vecs[idx].exp_terr));
    endtask

    task automatic model_read(input string name, input logic [24:0] addr, input int ack_delay, input logic [7:0] data);
        int waits, memrd_cnt;
        sb_q.push_back(model_din(addr, ack_delay, data));
        do_read(addr, ack_delay, data, waits, memrd_cnt);
        check_output(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        vecs[0] = '{25'h0010,      3, 8'h5A, 8'h5A, 4, 3, 1'b0};
        vecs[1] = '{25'h4000,      0, 8'h00, 8'hFF, 1, 0, 1'b0};
        vecs[2] = '{25'h3FFF,      1, 8'h33, 8'h33, 2, 1, 1'b0};
        vecs[3] = '{25'h0123,      4, 8'h44, 8'h44, 5, 4, 1'b0};
        vecs[4] = '{25'h100_0000,  0, 8'h00, 8'hFF, 1, 0, 1'b0};
        vecs[5] = '{25'h0020,      0, 8'h00, 8'hEE, 5, 4, 1'b1};

        repeat (2) @(negedge clk_sys);
        #1;
        check("rst_din", 32'(ioctl_din), 32'd0);
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_memrd", 32'(mem_rd), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset        = 1'b0;
        ioctl_upload = 1'b1;

        for (int i = 0; i < 6; i++) apply_stimulus(i);

        // New session clears the sticky timeout flag.
        @(negedge clk_sys); ioctl_upload = 1'b0;
        @(negedge clk_sys); ioctl_upload = 1'b1;
        @(negedge clk_sys); #1;
        check("session_terr_clr", 32'(timeout_err), 32'd0);
        check("session_sum_clr", 32'(upload_sum), 32'd0);

        // Wrong index is ignored.
        @(negedge clk_sys);
        ioctl_rd = 1'b1; ioctl_index = 8'd1; ioctl_addr = 25'h10;
        #1;
        check("idx_wait", 32'(ioctl_wait), 32'd0);
        @(negedge clk_sys);
        ioctl_rd = 1'b0; ioctl_index = 8'd0;
        #1;
        check("idx_memrd", 32'(mem_rd), 32'd0);
        check("idx_din", 32'(ioctl_din), 32'(last_din));

        // Abort in WAIT_ACK with a coincident ack, then a late ack in IDLE.
        @(negedge clk_sys);
        ioctl_rd = 1'b1; ioctl_addr = 25'h50;
        #1;
        check("abort_accept_wait", 32'(ioctl_wait), 32'd1);
        @(negedge clk_sys); ioctl_rd = 1'b0; #1;
        check("abort_memrd_pre", 32'(mem_rd), 32'd1);
        @(negedge clk_sys); ioctl_upload = 1'b0; mem_ack = 1'b1; mem_data = 8'h77;
        @(negedge clk_sys); mem_ack = 1'b0; #1;
        check("abort_memrd", 32'(mem_rd), 32'd0);
        check("abort_wait", 32'(ioctl_wait), 32'd0);
        check("abort_din", 32'(ioctl_din), 32'(last_din));
        @(negedge clk_sys); ioctl_upload = 1'b1; mem_ack = 1'b1; mem_data = 8'h66;
        @(negedge clk_sys); mem_ack = 1'b0; #1;
        check("late_ack_din", 32'(ioctl_din), 32'(last_din));
        check("late_ack_wait", 32'(ioctl_wait), 32'd0);

        // Checksum over data, data and a pad byte.
        model_read("sum_rd0", 25'h0001, 2, 8'h80);
        model_read("sum_rd1", 25'h0002, 1, 8'h90);
        model_read("sum_rd2", 25'h5000, 0, 8'h00);
`ifdef UPLOAD_CHECKSUM_EN
        check("upload_sum", 32'(upload_sum), 32'h0F);
`else
        check("upload_sum", 32'(upload_sum), 32'h00);
`endif

        model_read("timeout2", 25'h0040, 0, 8'h00);
        check("timeout2_terr", 32'(timeout_err), 32'd1);

        // Synchronous reset while waiting for an ack.
        @(negedge clk_sys); ioctl_rd = 1'b1; ioctl_addr = 25'h30;
        @(negedge clk_sys); ioctl_rd = 1'b0;
        @(negedge clk_sys); reset = 1'b1;
        @(negedge clk_sys); reset = 1'b0; #1;
        check("mid_rst_din", 32'(ioctl_din), 32'd0);
        check("mid_rst_wait", 32'(ioctl_wait), 32'd0);
        check("mid_rst_memrd", 32'(mem_rd), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_terr", 32'(timeout_err), 32'd0);
        check("mid_rst_sum", 32'(upload_sum), 32'd0);
        model_read("post_rst_rd", 25'h0003, 2, 8'hA5);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioctl_upload_server.md
# ioctl_upload_server

Core-side responder for the HPS ioctl upload (save/readback) path, the counterpart of the ioctl download write path into `soc`. When the HPS reads bytes from the core, this block turns each `ioctl_rd` strobe into a read on a variable-latency SoC memory port. It stretches the transfer with `ioctl_wait`, returns the byte on `ioctl_din`, and enforces a region bound and an ack timeout. It sits between the top-level ioctl bus and the SoC RAM's second port, in the `clk_sys` domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 14: memory address width; `mem_addr` = `ioctl_addr[ADDR_WIDTH-1:0]`.
- `REGION_SIZE`, 16384: number of valid bytes. Addresses at or above this read as padding.
- `UPLOAD_INDEX`, 8'd0: the only `ioctl_index` value this block serves.
- `TIMEOUT`, 255: the maximum number of cycles spent in WAIT_ACK (1..255).
- `PAD_BYTE`, 8'hFF: byte returned for out-of-range addresses.
- `ERR_BYTE`, 8'hEE: byte returned on timeout.

Ports (clock and reset first):
- `clk_sys` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ioctl_upload` in 1: upload session active.
- `ioctl_index` in 8: file/region index.
- `ioctl_rd` in 1: one-cycle read strobe.
- `ioctl_addr` in 25: byte address, valid with `ioctl_rd`.
- `ioctl_din` out 8: returned byte, held until the next completed read.
- `ioctl_wait` out 1: HPS must not issue a new `ioctl_rd` while high.
- `mem_rd` out 1: read request, level, held until `mem_ack` or abort.
- `mem_addr` out ADDR_WIDTH: request address, stable while `mem_rd` is high.
- `mem_ack` in 1: one-cycle data-valid strobe.
- `mem_data` in 8: valid with `mem_ack`.
- `timeout_err` out 1: sticky, set on any timeout, cleared at session start.
- `upload_sum` out 8: running checksum (see Configuration).

## Operation
- An access is **accepted** when `ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX) & state == IDLE`. In any other case `ioctl_rd` is ignored and no wait is raised.
- States:
  - IDLE: on accept with `ioctl_addr < REGION_SIZE`, latch the address and go to WAIT_ACK. On accept with the address out of range, go to DONE with `PAD_BYTE`.
  - WAIT_ACK: `mem_rd` = 1. On `mem_ack`, capture `mem_data` and go to DONE. If the cycle counter reaches `TIMEOUT` without an ack, capture `ERR_BYTE`, set `timeout_err`, drop `mem_rd`, and go to DONE.
  - DONE: drive the captured byte onto `ioctl_din`, then return to IDLE.
- `ioctl_wait` = accept (combinational) OR state ∈ {WAIT_ACK}. It deasserts in the cycle `ioctl_din` is updated.
- The range check uses the full 25-bit `ioctl_addr`.
- `ioctl_upload` falling in any state: go to IDLE next cycle, `mem_rd` = 0, `ioctl_wait` = 0, and `ioctl_din` is unchanged. A late `mem_ack` received in IDLE is ignored.
- A rising edge of `ioctl_upload` (registered previous value 0, current 1) clears `timeout_err` and `upload_sum`.
- `mem_ack` arriving outside WAIT_ACK is ignored.

## Timing
- Reset (synchronous): state IDLE, `ioctl_din` = 0, `ioctl_wait` = 0, `mem_rd` = 0, `mem_addr` = 0, `timeout_err` = 0, `upload_sum` = 0, timeout counter = 0.
- Accept at cycle N: `ioctl_wait` = 1 in N. From N+1, `mem_rd` = 1 and `mem_addr` is valid.
- `mem_ack` at cycle M (M ≥ N+1): `ioctl_din` = data and `ioctl_wait` = 0 at M+1. An ack in cycle N+1 gives a 2-cycle total latency.
- Out-of-range access: `ioctl_wait` is high in N only, and `ioctl_din` = `PAD_BYTE` at N+1.
- Timeout: the counter starts at 1 in cycle N+1. In the cycle it equals `TIMEOUT` with no ack, the FSM moves to DONE. `ioctl_din` = `ERR_BYTE` one cycle later.
- An ack in the same cycle the counter hits `TIMEOUT` counts as success; ack has priority.
- `ioctl_upload` falling in the same cycle as `mem_ack`: abort wins and `ioctl_din` is not updated.

## Configuration
- `UPLOAD_CHECKSUM_EN` defined: `upload_sum` is an 8-bit modulo-256 sum of every byte delivered to `ioctl_din`, including pad and error bytes. It updates in the same cycle as `ioctl_din` and clears at session start and on reset.
- `UPLOAD_CHECKSUM_EN` undefined: `upload_sum` is constant 0 and no adder is built.

## Test plan
- In-range read: upload=1, index=0, rd at addr 0x0010, memory acks 3 cycles later with 0x5A. Required: wait high for 4 cycles, `mem_addr` = 0x0010, `ioctl_din` = 0x5A, wait low the same cycle.
- Out-of-range: rd at addr 0x4000 with `REGION_SIZE` = 16384. Required: `mem_rd` never rises, wait high for 1 cycle, `ioctl_din` = 0xFF.
- Timeout: `TIMEOUT` = 4 and the memory never acks. Required: `mem_rd` high for 4 cycles, `ioctl_din` = 0xEE, `timeout_err` = 1. Starting a new session clears it.
- Index filter and abort:
  - rd with index = 1: no wait and no `mem_rd`.
  - rd with index 0, then `ioctl_upload` dropped in WAIT_ACK: `mem_rd` = 0 next cycle and `ioctl_din` is unchanged.
  - A late ack is ignored.
- Checksum (with `UPLOAD_CHECKSUM_EN`): reads return 0x80, 0x90, and one pad byte. Required: `upload_sum` = 0x0F.
- Reset mid-WAIT_ACK: all outputs return to their reset values next cycle. A following read completes normally.
